// File: rtl/seg7_scan_driver_if.sv
// Load-side bus for seg7_scan_driver: one packed hex value per transfer.
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  // Handshake: a transfer happens on a rising clk edge where data_valid && data_ready.
  // The producer holds data stable while data_valid is high and ready is low;
  // data_ready depends only on consumer state, never on data_valid.
  logic [4*N_DIGITS-1:0] data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Double-buffered, time-multiplexed scan driver for common-anode 7-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN enables leading-zero blanking on digit_blank.
module seg7_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  seg7_scan_driver_if.slave   bus,
  output logic [3:0]          digit_q,
  output logic [N_DIGITS-1:0] digit_sel,
  output logic                digit_blank,
  output logic                scan_tick
);

  localparam int DW = 4 * N_DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic [DW-1:0]       shadow;
  logic [DW-1:0]       disp;
  logic                pending;

  logic                tick;
  logic                frame_end;
  logic                xfer;
  logic [3:0]          cur_nib;
  logic [N_DIGITS-1:0] sel_next;
  logic                blank_next;

  assign tick           = (pcnt == PCNT_MAX);
  assign frame_end      = tick && (idx == IDX_MAX);
  assign bus.data_ready = !pending;
  assign xfer           = bus.data_valid && !pending;

  // Prescaler and digit index; idx wraps by compare so non-power-of-2 counts work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      if (tick) begin
        pcnt <= '0;
        idx  <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // A transfer can only happen while pending is clear, so it never collides with
  // the disp load; a transfer on a boundary waits for the next boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (xfer) begin
        shadow  <= bus.data;
        pending <= 1'b1;
      end else if (frame_end && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib  = '0;
    sel_next = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib     = disp[4*i +: 4];
        sel_next[i] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[i]: nibbles i..N_DIGITS-1 of disp are all zero.
  logic [N_DIGITS-1:1] upper_zero;

  always_comb begin
    upper_zero             = '0;
    upper_zero[N_DIGITS-1] = (disp[DW-1 -: 4] == 4'h0);
    for (int i = N_DIGITS - 2; i >= 1; i--) begin
      upper_zero[i] = upper_zero[i+1] && (disp[4*i +: 4] == 4'h0);
    end
    blank_next = 1'b0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) blank_next = upper_zero[i];
    end
  end
`else
  assign blank_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q     <= '0;
      digit_sel   <= '1;
      digit_blank <= 1'b0;
      scan_tick   <= 1'b0;
    end else begin
      digit_q     <= cur_nib;
      digit_sel   <= sel_next;
      digit_blank <= blank_next;
      scan_tick   <= tick;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed scan driver for a bank of common-anode seven-segment digits. Accepts a packed hex value over a valid/ready handshake and double-buffers it so a display update never tears mid-frame. Presents one 4-bit nibble at a time to the downstream hex-to-segment decoder, with a matching active-low digit select, cycling through the digits at a prescaled rate.

## Interface
Parameters:
- N_DIGITS, 4, number of digits scanned; valid range 2–8.
- PRESCALE, 50000, clk cycles each digit stays selected; minimum 2.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- data  in  4*N_DIGITS  packed hex value; data[3:0] is digit 0, the least significant digit.
- data_valid  in  1  data is offered this cycle.
- data_ready  out  1  the shadow register is free; a transfer occurs when data_valid && data_ready.
- digit_q  out  4  nibble for the currently selected digit; feeds the decoder input.
- digit_sel  out  N_DIGITS  active-low one-hot digit enable.
- digit_blank  out  1  1 = the decoder output is to be forced dark for this digit.
- scan_tick  out  1  one-cycle pulse when the selected digit advances.

## Operation
- **Prescaler.** pcnt counts 0 to PRESCALE-1 and wraps. tick = (pcnt == PRESCALE-1).
- **Digit index.**
  - On each tick, idx increments.
  - At N_DIGITS-1 the next tick wraps idx to 0. This wrapping tick is the frame boundary.
- **Buffering.** There are two registers, shadow and disp, plus a pending flag.
  - data_ready = !pending. It is combinational from the flag.
  - On a transfer: shadow <= data and pending <= 1.
  - At a frame boundary with pending = 1: disp <= shadow and pending <= 0.
  - A transfer and a frame boundary in the same cycle with pending = 0: the new data enters shadow only. It reaches disp at the following frame boundary.
  - pending = 1 blocks data_ready, so a transfer and a disp load can never conflict.
- **Outputs.** All outputs are registered and loaded every cycle from the pre-edge state:
  - digit_q <= disp[4*idx +: 4]
  - digit_sel <= ~(1 << idx)
  - scan_tick <= tick
  - digit_blank is set as described under Configuration.
- **Width rules.**
  - pcnt is $clog2(PRESCALE) bits.
  - idx is $clog2(N_DIGITS) bits. It wraps by compare, not by natural overflow, so non-power-of-2 values of N_DIGITS work.
- **Reset mid-operation.** Reset clears all state immediately. Any pending data is discarded.

## Timing
- **Reset values:**
  - digit_q = 0
  - digit_sel = all ones (all digits off)
  - digit_blank = 0
  - scan_tick = 0
  - data_ready = 1
  - internal state: pcnt = 0, idx = 0, disp = 0, shadow = 0, pending = 0
- **Output latency.** Outputs lag the internal state by 1 cycle. The first clk edge after reset release drives digit_sel = ~1 with digit_q = 0.
- **Dwell.** Each digit is selected for exactly PRESCALE cycles. A full frame is N_DIGITS*PRESCALE cycles.
- **Update latency.**
  - A transfer appears on digit_q no earlier than the first frame boundary after it, plus 1 cycle.
  - The worst case is N_DIGITS*PRESCALE + 1 cycles.
- **Ready.** data_ready drops in the cycle after a transfer. It rises in the cycle after the disp load.

## Configuration
- LEADING_ZERO_BLANK_EN
  - **Defined:** digit_blank <= 1 for index i when i != 0 and nibbles i through N_DIGITS-1 of disp are all zero. digit_sel is still driven normally, and the decoder stage gates the segments. Digit 0 is never blanked.
  - **Undefined:** digit_blank is tied to 0. All digits always show, including leading zeros.

## Test plan
Parameters for all scenarios: N_DIGITS = 4, PRESCALE = 4.

1. **Reset.** Assert reset_n = 0 mid-scan with pending = 1 -> outputs go immediately to their reset values and data_ready = 1. After release, digit_sel = 4'b1110 and digit_q = 0.
2. **Scan order.** Transfer 16'h4321, wait one frame -> digit_q sequence 1, 2, 3, 4, each held 4 cycles. digit_sel sequence 1110, 1101, 1011, 0111. scan_tick pulses every 4 cycles.
3. **Backpressure.**
   - Transfer 16'hAAAA, then hold data_valid = 1 with 16'h5555 -> data_ready = 0 until the frame boundary; 16'h5555 is accepted the cycle after data_ready rises.
   - 16'hAAAA is displayed for one full frame with no mixing of A and 5 within that frame.
4. **Simultaneous event.** Transfer 16'h00F0 on the same cycle as a frame boundary -> the current frame still shows the old value. 16'h00F0 appears from the next boundary.
5. **Leading-zero blanking** (macro defined). Display 16'h00F0 -> digit_blank = 1 for digits 2 and 3, and 0 for digits 0 and 1. Display 16'h0000 -> only digit 0 is unblanked.
6. **Macro undefined.** Same stimulus as scenario 5 -> digit_blank = 0 throughout.
